// File: rtl/pantalla_refresh_ctrl.sv
// Frame-refresh sequencer: streams 8 pages x 131 bytes (3 address commands + 128 columns) to an SSD1306 panel over 4-wire SPI.
// Define PANTALLA_CONT_EN for continuous back-to-back frame scanning after a single start.
module pantalla_refresh_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] ram_addr_rd,
  output logic       ram_rd,
  input  logic [7:0] ram_d_out,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  // The NEXT decision has no cycle of its own; it is taken on the last SHIFT cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LATCH = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] LAST_BYTE  = 8'd130;
  localparam logic [7:0] FIRST_DATA = 8'd3;

  function automatic logic [7:0] cmd_byte(input logic [7:0] idx, input logic [2:0] pg);
    case (idx)
      8'd0:    return {5'b10110, pg};
      8'd1:    return 8'h00;
      8'd2:    return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  state_t     state_r, state_nx_s;
  logic [2:0] page_r, page_nx_s;
  logic [7:0] byte_idx_r, byte_idx_nx_s;
  logic [7:0] div_cnt_r, div_cnt_nx_s;
  logic       half_r, half_nx_s;
  logic [2:0] bit_cnt_r, bit_cnt_nx_s;
  logic [7:0] shreg_r, shreg_nx_s;
  logic       busy_nx_s, done_nx_s, ram_rd_nx_s, cs_n_nx_s, dc_nx_s, sclk_nx_s, mosi_nx_s;
  logic [9:0] ram_addr_nx_s;
  logic       enter_load_s;
  logic [6:0] col_s;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nx_s    = state_r;
    page_nx_s     = page_r;
    byte_idx_nx_s = byte_idx_r;
    div_cnt_nx_s  = div_cnt_r;
    half_nx_s     = half_r;
    bit_cnt_nx_s  = bit_cnt_r;
    shreg_nx_s    = shreg_r;
    busy_nx_s     = busy;
    done_nx_s     = 1'b0;
    ram_rd_nx_s   = 1'b0;
    ram_addr_nx_s = ram_addr_rd;
    cs_n_nx_s     = lcd_cs_n;
    dc_nx_s       = lcd_dc;
    sclk_nx_s     = lcd_sclk;
    mosi_nx_s     = lcd_mosi;
    enter_load_s  = 1'b0;
    col_s         = 7'd0;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s    = LOAD;
          page_nx_s     = 3'd0;
          byte_idx_nx_s = 8'd0;
          busy_nx_s     = 1'b1;
          cs_n_nx_s     = 1'b0;
          enter_load_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: state_nx_s = LATCH;
      LATCH: begin
        state_nx_s   = SHIFT;
        shreg_nx_s   = lcd_dc ? ram_d_out : cmd_byte(byte_idx_r, page_r);
        mosi_nx_s    = shreg_nx_s[7];
        sclk_nx_s    = 1'b0;
        div_cnt_nx_s = 8'd0;
        half_nx_s    = 1'b0;
        bit_cnt_nx_s = 3'd0;
      end
      SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_nx_s = 8'd0;
          if (!half_r) begin
            half_nx_s = 1'b1;
            sclk_nx_s = 1'b1;
          end else begin
            half_nx_s    = 1'b0;
            sclk_nx_s    = 1'b0;
            shreg_nx_s   = {shreg_r[6:0], 1'b0};
            mosi_nx_s    = shreg_r[6];
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (byte_idx_r < LAST_BYTE) begin
                byte_idx_nx_s = byte_idx_r + 8'd1;
                state_nx_s    = LOAD;
                enter_load_s  = 1'b1;
              end else if (page_r < 3'd7) begin
                page_nx_s     = page_r + 3'd1;
                byte_idx_nx_s = 8'd0;
                state_nx_s    = LOAD;
                enter_load_s  = 1'b1;
              end else begin
                state_nx_s = DONE;
                done_nx_s  = 1'b1;
`ifdef PANTALLA_CONT_EN
                busy_nx_s  = 1'b1;
`else
                busy_nx_s  = 1'b0;
`endif
                cs_n_nx_s  = 1'b1;
                dc_nx_s    = 1'b0;
                mosi_nx_s  = 1'b0;
              end
            end else begin
              state_nx_s = SHIFT;
            end
          end
        end else begin
          div_cnt_nx_s = div_cnt_r + 8'd1;
        end
      end
      DONE: begin
`ifdef PANTALLA_CONT_EN
        state_nx_s    = LOAD;
        page_nx_s     = 3'd0;
        byte_idx_nx_s = 8'd0;
        busy_nx_s     = 1'b1;
        cs_n_nx_s     = 1'b0;
        enter_load_s  = 1'b1;
`else
        state_nx_s = IDLE;
`endif
      end
      default: state_nx_s = IDLE;
    endcase

    // Byte kind and RAM read are presented in the LOAD cycle itself, so they are set on entry.
    if (enter_load_s) begin
      col_s         = byte_idx_nx_s[6:0] - 7'd3;
      dc_nx_s       = (byte_idx_nx_s >= FIRST_DATA);
      ram_rd_nx_s   = dc_nx_s;
      ram_addr_nx_s = dc_nx_s ? {page_nx_s, col_s} : ram_addr_rd;
    end else begin
      col_s = 7'd0;
    end
  end

  // State, counters and registered panel/RAM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      page_r      <= 3'd0;
      byte_idx_r  <= 8'd0;
      div_cnt_r   <= 8'd0;
      half_r      <= 1'b0;
      bit_cnt_r   <= 3'd0;
      shreg_r     <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_rd      <= 1'b0;
      ram_addr_rd <= 10'd0;
      lcd_cs_n    <= 1'b1;
      lcd_dc      <= 1'b0;
      lcd_sclk    <= 1'b0;
      lcd_mosi    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      page_r      <= page_nx_s;
      byte_idx_r  <= byte_idx_nx_s;
      div_cnt_r   <= div_cnt_nx_s;
      half_r      <= half_nx_s;
      bit_cnt_r   <= bit_cnt_nx_s;
      shreg_r     <= shreg_nx_s;
      busy        <= busy_nx_s;
      done        <= done_nx_s;
      ram_rd      <= ram_rd_nx_s;
      ram_addr_rd <= ram_addr_nx_s;
      lcd_cs_n    <= cs_n_nx_s;
      lcd_dc      <= dc_nx_s;
      lcd_sclk    <= sclk_nx_s;
      lcd_mosi    <= mosi_nx_s;
    end
  end

endmodule

// File: tb/tb_pantalla_refresh_ctrl.sv
// Directed bench for pantalla_refresh_ctrl: SPI byte capture, RAM model, frame timing and reset behaviour.
module tb_pantalla_refresh_ctrl;
  localparam int CLK_DIV   = 1;
  localparam int FRAME_CYC = 1048 * (2 + 16 * CLK_DIV) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, ram_rd, lcd_cs_n, lcd_dc, lcd_sclk, lcd_mosi;
  logic [9:0] ram_addr_rd;
  logic [7:0] ram_d_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pantalla_refresh_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr_rd(ram_addr_rd), .ram_rd(ram_rd), .ram_d_out(ram_d_out),
    .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc), .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_data(input logic [9:0] a);
    return a[7:0] ^ {5'b00000, a[9:7]};
  endfunction

  // RAM read port: data appears on the negedge after the strobe.
  always @(negedge clk) if (ram_rd) ram_d_out <= exp_data(ram_addr_rd);

  int         rx_bits = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       sclk_prev = 1'b0;
  logic [8:0] rx_q[$];
  logic [9:0] addr_q[$];
  int         rd_cnt = 0;
  int         done_cnt = 0;

  // Panel-side capture: one bit per sclk rise, tagged with lcd_dc; RAM strobe and done counting.
  always @(negedge clk) begin
    if (rst || lcd_cs_n) begin
      rx_bits = 0;
    end else if (lcd_sclk && !sclk_prev) begin
      rx_sh   = {rx_sh[6:0], lcd_mosi};
      rx_bits = rx_bits + 1;
      if (rx_bits == 8) begin
        rx_q.push_back({lcd_dc, rx_sh});
        rx_bits = 0;
      end
    end
    sclk_prev = lcd_sclk;
    if (ram_rd) begin
      rd_cnt = rd_cnt + 1;
      addr_q.push_back(ram_addr_rd);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name, output int c_done, output bit ok);
    ok = 1'b0;
    c_done = 0;
    for (int i = 0; i < FRAME_CYC + 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        c_done = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, FRAME_CYC + 100);
    end
  endtask

  task automatic check_idle(input string name);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", name, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", name, done); end
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL %s ram_rd: got %b want 0", name, ram_rd); end
    checks++; if (ram_addr_rd !== 10'd0) begin errors++; $display("FAIL %s ram_addr_rd: got %h want 000", name, ram_addr_rd); end
    checks++; if (lcd_cs_n !== 1'b1) begin errors++; $display("FAIL %s lcd_cs_n: got %b want 1", name, lcd_cs_n); end
    checks++; if (lcd_dc !== 1'b0) begin errors++; $display("FAIL %s lcd_dc: got %b want 0", name, lcd_dc); end
    checks++; if (lcd_sclk !== 1'b0) begin errors++; $display("FAIL %s lcd_sclk: got %b want 0", name, lcd_sclk); end
    checks++; if (lcd_mosi !== 1'b0) begin errors++; $display("FAIL %s lcd_mosi: got %b want 0", name, lcd_mosi); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check_idle("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start busy: got %b want 0", busy); end
    checks++; if (rd_cnt != 0 || rx_q.size() != 0) begin
      errors++; $display("FAIL reset_start activity: ram_rd pulses %0d bytes %0d want 0 0", rd_cnt, rx_q.size());
    end
  endtask

  task automatic test_frame();
    int b, a, r0, d0, c0, cd, bad;
    bit ok;
    logic [8:0] want;
    logic [2:0] pv;
    logic [6:0] cv;
    logic [9:0] av;
    b = rx_q.size(); a = addr_q.size(); r0 = rd_cnt; d0 = done_cnt;
    pulse_start(c0);
    checks++; if (busy !== 1'b1 || lcd_cs_n !== 1'b0) begin
      errors++; $display("FAIL frame_accept: busy %b cs_n %b want 1 0", busy, lcd_cs_n);
    end
    wait_done("frame", cd, ok);
    if (ok) begin
      checks++; if (cd - c0 + 1 != FRAME_CYC) begin
        errors++; $display("FAIL frame_done_cycle: got %0d want %0d", cd - c0 + 1, FRAME_CYC);
      end
      checks++; if (lcd_cs_n !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL frame_done_outputs: cs_n %b busy %b want 1 0", lcd_cs_n, busy);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || lcd_cs_n !== 1'b1) begin
        errors++; $display("FAIL frame_idle_after: done %b cs_n %b want 0 1", done, lcd_cs_n);
      end
    end
    checks++; if (rx_q.size() - b != 1048) begin
      errors++; $display("FAIL frame_byte_count: got %0d want 1048", rx_q.size() - b);
    end
    if (rx_q.size() - b >= 1048) begin
      checks++; if (rx_q[b] !== {1'b0, 8'hB0}) begin errors++; $display("FAIL header0: got %h want 0b0", rx_q[b]); end
      checks++; if (rx_q[b+1] !== {1'b0, 8'h00}) begin errors++; $display("FAIL header1: got %h want 000", rx_q[b+1]); end
      checks++; if (rx_q[b+2] !== {1'b0, 8'h10}) begin errors++; $display("FAIL header2: got %h want 010", rx_q[b+2]); end
      checks++; if (rx_q[b+3][8] !== 1'b1) begin errors++; $display("FAIL byte4_dc: got %b want 1", rx_q[b+3][8]); end
      checks++; if (rx_q[b+917] !== {1'b0, 8'hB7}) begin errors++; $display("FAIL page7_header: got %h want 0b7", rx_q[b+917]); end
      av = 10'h380;
      checks++; if (rx_q[b+920] !== {1'b1, exp_data(av)}) begin
        errors++; $display("FAIL page7_col0: got %h want %h", rx_q[b+920], {1'b1, exp_data(av)});
      end
      bad = 0;
      for (int p = 0; p < 8; p++) begin
        for (int i = 0; i < 131; i++) begin
          pv = p[2:0];
          cv = 7'(i - 3);
          if (i == 0) want = {1'b0, 5'b10110, pv};
          else if (i == 1) want = {1'b0, 8'h00};
          else if (i == 2) want = {1'b0, 8'h10};
          else want = {1'b1, exp_data({pv, cv})};
          if (rx_q[b + p*131 + i] !== want) begin
            if (bad == 0) $display("FAIL frame_stream at page %0d byte %0d: got %h want %h", p, i, rx_q[b + p*131 + i], want);
            bad++;
          end
        end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL frame_stream: %0d bad bytes want 0", bad); end
    end
    checks++; if (rd_cnt - r0 != 1024) begin errors++; $display("FAIL ram_rd_count: got %0d want 1024", rd_cnt - r0); end
    if (addr_q.size() - a >= 1024) begin
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
        av = k[9:0];
        if (addr_q[a+k] !== av) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL ram_addr_order: %0d out of order want 0", bad); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_start_while_busy();
    int r0, d0, c0, cd;
    bit ok;
    r0 = rd_cnt; d0 = done_cnt;
    pulse_start(c0);
    repeat (499) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", cd, ok);
    repeat (60) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (rd_cnt - r0 != 1024) begin errors++; $display("FAIL busy_start_ram_rd: got %0d want 1024", rd_cnt - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int c0, b, d0;
    bit hit;
    pulse_start(c0);
    hit = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (ram_rd === 1'b1 && ram_addr_rd === 10'h128) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midframe_reach: page 2 col 40 read not seen"); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || lcd_cs_n !== 1'b0) begin
      errors++; $display("FAIL midframe_active: busy %b cs_n %b want 1 0", busy, lcd_cs_n);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_idle("midframe_reset");
    rst = 1'b0;
    b = rx_q.size();
    pulse_start(c0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_q.size() > b) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL restart_byte: no byte within 200 cycles");
    end else if (rx_q[b] !== {1'b0, 8'hB0}) begin
      errors++; $display("FAIL restart_byte: got %h want 0b0", rx_q[b]);
    end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL midframe_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_cont();
    int c0, c1, c2, c3;
    bit ok;
    pulse_start(c0);
    wait_done("cont1", c1, ok);
    checks++; if (c1 - c0 + 1 != FRAME_CYC) begin errors++; $display("FAIL cont_first: got %0d want %0d", c1 - c0 + 1, FRAME_CYC); end
    checks++; if (lcd_cs_n !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cont_gap1: cs_n %b busy %b want 1 1", lcd_cs_n, busy); end
    @(negedge clk);
    checks++; if (lcd_cs_n !== 1'b0) begin errors++; $display("FAIL cont_resume1: cs_n got %b want 0", lcd_cs_n); end
    wait_done("cont2", c2, ok);
    checks++; if (c2 - c1 != FRAME_CYC) begin errors++; $display("FAIL cont_period1: got %0d want %0d", c2 - c1, FRAME_CYC); end
    @(negedge clk);
    checks++; if (lcd_cs_n !== 1'b0) begin errors++; $display("FAIL cont_resume2: cs_n got %b want 0", lcd_cs_n); end
    wait_done("cont3", c3, ok);
    checks++; if (c3 - c2 != FRAME_CYC) begin errors++; $display("FAIL cont_period2: got %0d want %0d", c3 - c2, FRAME_CYC); end
  endtask

  initial begin
    test_reset();
`ifdef PANTALLA_CONT_EN
    test_cont();
`else
    test_frame();
    test_start_while_busy();
    test_reset_mid_frame();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
